// File: rtl/fixed_to_float_rne_if.sv
// Handshake bus for the fixed-point to single-precision converter.
// The slave modport is the converter side; the master modport is the producer/consumer side.
interface fixed_to_float_rne_if #(
    parameter int p_IN_WIDTH = 32
);
    logic                  i_VALID;
    logic                  o_READY;
    logic [p_IN_WIDTH-1:0] i_FIXED_WORD;
    logic                  o_VALID;
    logic                  i_READY;
    logic [31:0]           o_FLOAT_WORD;
    logic                  o_INEXACT;
    logic                  o_ZERO;

    modport slave (
        input  i_VALID, i_FIXED_WORD, i_READY,
        output o_READY, o_VALID, o_FLOAT_WORD, o_INEXACT, o_ZERO
    );

    modport master (
        output i_VALID, i_FIXED_WORD, i_READY,
        input  o_READY, o_VALID, o_FLOAT_WORD, o_INEXACT, o_ZERO
    );
endinterface

// File: rtl/fixed_to_float_rne.sv
// Three-stage signed fixed-point to IEEE-754 single conversion, round-to-nearest-even.
// Stages: sign/magnitude, leading-one normalise, round and pack; all stages stall together.
module fixed_to_float_rne #(
    parameter int p_IN_WIDTH  = 32,
    parameter int p_FRAC_BITS = 0
) (
    input  logic                  i_CLK,
    input  logic                  i_RST,
    fixed_to_float_rne_if.slave   bus
);
    // Normalised magnitude without its leading one, padded so guard/sticky always exist.
    localparam int             LP_NW   = p_IN_WIDTH + 23;
    localparam logic [6:0]     LP_MSB  = 7'(p_IN_WIDTH - 1);
    localparam logic [7:0]     LP_FRAC = 8'(p_FRAC_BITS);

    logic                  adv_s;

    logic                  s1_valid_q, s1_valid_d;
    logic                  s1_sign_q,  s1_sign_d;
    logic [p_IN_WIDTH-1:0] s1_mag_q,   s1_mag_d;

    logic                  s2_valid_q, s2_valid_d;
    logic                  s2_sign_q,  s2_sign_d;
    logic                  s2_zero_q,  s2_zero_d;
    logic [5:0]            s2_k_q,     s2_k_d;
    logic [p_IN_WIDTH-2:0] s2_frac_q,  s2_frac_d;

    logic                  o_valid_q,  o_valid_d;
    logic [31:0]           o_word_q,   o_word_d;
    logic                  o_inexact_q, o_inexact_d;
    logic                  o_zero_q,   o_zero_d;

    logic [5:0]            k_s;
    logic [6:0]            shamt_s;
    logic [LP_NW-1:0]      ext_s;
    logic [22:0]           mant_s;
    logic                  guard_s;
    logic                  sticky_s;
    logic                  round_up_s;
    logic [23:0]           mant_rnd_s;
    logic [7:0]            exp_s;

    // Global advance: everything moves when the output slot is free or being taken.
    always_comb begin
        adv_s = bus.i_READY | ~o_valid_q;
    end

    assign bus.o_READY      = adv_s;
    assign bus.o_VALID      = o_valid_q;
    assign bus.o_FLOAT_WORD = o_word_q;
    assign bus.o_INEXACT    = o_inexact_q;
    assign bus.o_ZERO       = o_zero_q;

    // Stage 1 next-state: sign and unsigned magnitude (most negative input stays representable).
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_mag_d   = s1_mag_q;
        if (adv_s) begin
            s1_valid_d = bus.i_VALID;
            s1_sign_d  = bus.i_FIXED_WORD[p_IN_WIDTH-1];
            if (bus.i_FIXED_WORD[p_IN_WIDTH-1]) begin
                s1_mag_d = ~bus.i_FIXED_WORD + {{(p_IN_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                s1_mag_d = bus.i_FIXED_WORD;
            end
        end else begin
            s1_mag_d = s1_mag_q;
        end
    end

    // Stage 2 next-state: leading-one index and left normalisation.
    always_comb begin
        k_s = 6'd0;
        for (int i = 0; i < p_IN_WIDTH; i++) begin
            if (s1_mag_q[i]) begin
                k_s = 6'(i);
            end else begin
                k_s = k_s;
            end
        end
        shamt_s    = LP_MSB - {1'b0, k_s};
        s2_valid_d = s2_valid_q;
        s2_sign_d  = s2_sign_q;
        s2_zero_d  = s2_zero_q;
        s2_k_d     = s2_k_q;
        s2_frac_d  = s2_frac_q;
        if (adv_s) begin
            s2_valid_d = s1_valid_q;
            s2_sign_d  = s1_sign_q;
            s2_zero_d  = ~|s1_mag_q;
            s2_k_d     = k_s;
            s2_frac_d  = s1_mag_q[p_IN_WIDTH-2:0] << shamt_s;
        end else begin
            s2_frac_d  = s2_frac_q;
        end
    end

    // Stage 3 next-state: round to nearest even, carry into exponent, pack.
    always_comb begin
        ext_s      = {s2_frac_q, 24'd0};
        mant_s     = ext_s[LP_NW-1 -: 23];
        guard_s    = ext_s[LP_NW-24];
        sticky_s   = |ext_s[LP_NW-25:0];
        round_up_s = guard_s & (sticky_s | mant_s[0]);
        mant_rnd_s = {1'b0, mant_s} + {23'd0, round_up_s};
        exp_s      = 8'd127 + {2'b00, s2_k_q} - LP_FRAC + {7'd0, mant_rnd_s[23]};
        o_valid_d   = o_valid_q;
        o_word_d    = o_word_q;
        o_inexact_d = o_inexact_q;
        o_zero_d    = o_zero_q;
        if (adv_s) begin
            o_valid_d = s2_valid_q;
            if (s2_zero_q) begin
                o_word_d    = 32'h0000_0000;
                o_inexact_d = 1'b0;
                o_zero_d    = 1'b1;
            end else begin
                o_word_d    = {s2_sign_q, exp_s, mant_rnd_s[22:0]};
                o_inexact_d = guard_s | sticky_s;
                o_zero_d    = 1'b0;
            end
        end else begin
            o_valid_d = o_valid_q;
        end
    end

    // Stage 1 registers.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_mag_q   <= {p_IN_WIDTH{1'b0}};
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_sign_q  <= s1_sign_d;
            s1_mag_q   <= s1_mag_d;
        end
    end

    // Stage 2 registers.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            s2_valid_q <= 1'b0;
            s2_sign_q  <= 1'b0;
            s2_zero_q  <= 1'b0;
            s2_k_q     <= 6'd0;
            s2_frac_q  <= {(p_IN_WIDTH-1){1'b0}};
        end else begin
            s2_valid_q <= s2_valid_d;
            s2_sign_q  <= s2_sign_d;
            s2_zero_q  <= s2_zero_d;
            s2_k_q     <= s2_k_d;
            s2_frac_q  <= s2_frac_d;
        end
    end

    // Output registers.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            o_valid_q   <= 1'b0;
            o_word_q    <= 32'h0000_0000;
            o_inexact_q <= 1'b0;
            o_zero_q    <= 1'b0;
        end else begin
            o_valid_q   <= o_valid_d;
            o_word_q    <= o_word_d;
            o_inexact_q <= o_inexact_d;
            o_zero_q    <= o_zero_d;
        end
    end
endmodule

// File: tb/tb_fixed_to_float_rne.sv
// Self-checking bench: directed corner vectors, backpressure, mid-stream reset and random traffic
// against an integer reference model; a second instance covers 16 fractional bits.
module tb_fixed_to_float_rne;
    typedef struct packed {
        logic        zero;
        logic        inexact;
        logic [31:0] word;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    res_t exp_q[$];
    logic stall_seen = 1'b0;
    res_t stall_res;

    always #5 clk = ~clk;

    fixed_to_float_rne_if #(.p_IN_WIDTH(32)) bus_a ();
    fixed_to_float_rne_if #(.p_IN_WIDTH(32)) bus_b ();

    fixed_to_float_rne #(.p_IN_WIDTH(32), .p_FRAC_BITS(0)) dut_a (
        .i_CLK (clk),
        .i_RST (rst),
        .bus   (bus_a)
    );

    fixed_to_float_rne #(.p_IN_WIDTH(32), .p_FRAC_BITS(16)) dut_b (
        .i_CLK (clk),
        .i_RST (rst),
        .bus   (bus_b)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Value-level reference: integer magnitude, divide into kept/remainder parts, compare to half.
    function automatic res_t ref_model(input logic [31:0] w, input int frac);
        res_t   r;
        longint sw, mag, q, rem, half;
        int     k, sh;
        r  = '0;
        sw = longint'($signed(w));
        mag = (sw < 0) ? -sw : sw;
        if (mag == 0) begin
            r.zero = 1'b1;
            return r;
        end
        k = 0;
        while ((mag >> (k + 1)) != 0) k++;
        if (k > 23) begin
            sh   = k - 23;
            q    = mag >> sh;
            rem  = mag - (q << sh);
            half = longint'(1) << (sh - 1);
            if (rem > half || (rem == half && q[0])) q++;
            r.inexact = (rem != 0);
            if (q == (longint'(1) << 24)) begin
                q = q >> 1;
                k++;
            end
        end else begin
            q = mag << (23 - k);
        end
        r.word = {w[31], 8'(127 + k - frac), q[22:0]};
        return r;
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        case ($urandom_range(0, 4))
            0: w = $urandom;
            1: w = 32'($urandom_range(0, 255));
            2: w = 32'h1 << $urandom_range(0, 31);
            3: w = (32'h1 << $urandom_range(24, 30)) | 32'($urandom_range(0, 511));
            4: w = -32'($urandom_range(0, 70000));
            default: w = $urandom;
        endcase
        return w;
    endfunction

    function automatic res_t cur_a();
        return {bus_a.o_ZERO, bus_a.o_INEXACT, bus_a.o_FLOAT_WORD};
    endfunction

    // One cycle on instance A, called just after a falling edge; samples 1 time unit later.
    task automatic drive_cycle(input logic v, input logic [31:0] w, input logic r, input res_t e,
                               output logic acc, output logic ov);
        res_t x;
        bus_a.i_VALID      = v;
        bus_a.i_FIXED_WORD = w;
        bus_a.i_READY      = r;
        #1;
        ov = bus_a.o_VALID;
        if (stall_seen)
            check_val("stall_hold", 64'({bus_a.o_VALID, cur_a()}), 64'({1'b1, stall_res}));
        if (bus_a.o_VALID && r) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_out", 64'(exp_q.size()), 64'd1);
            end else begin
                x = exp_q.pop_front();
                check_val("result", 64'(cur_a()), 64'(x));
            end
        end
        acc = v && bus_a.o_READY;
        if (acc) exp_q.push_back(e);
        stall_seen = bus_a.o_VALID && !r;
        stall_res  = cur_a();
        @(negedge clk);
    endtask

    task automatic drain();
        logic acc, ov;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++)
            drive_cycle(1'b0, 32'h0, 1'b1, '0, acc, ov);
        check_val("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic run_b(input string tag, input logic [31:0] w, input res_t e);
        int t;
        bus_b.i_VALID      = 1'b1;
        bus_b.i_FIXED_WORD = w;
        @(negedge clk);
        bus_b.i_VALID = 1'b0;
        t = 0;
        #1;
        while (!bus_b.o_VALID && t < 10) begin
            @(negedge clk);
            #1;
            t++;
        end
        check_val(tag, 64'({bus_b.o_VALID, bus_b.o_ZERO, bus_b.o_INEXACT, bus_b.o_FLOAT_WORD}),
                  64'({1'b1, e}));
        @(negedge clk);
    endtask

    logic [31:0] dir_in  [7] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF,
                                 32'h0100_0001, 32'h0100_0003, 32'h0000_0000};
    res_t        dir_exp [7] = '{{1'b0, 1'b0, 32'h3F80_0000}, {1'b0, 1'b0, 32'hBF80_0000},
                                 {1'b0, 1'b0, 32'hCF00_0000}, {1'b0, 1'b1, 32'h4F00_0000},
                                 {1'b0, 1'b1, 32'h4B80_0000}, {1'b0, 1'b1, 32'h4B80_0002},
                                 {1'b1, 1'b0, 32'h0000_0000}};

    initial begin
        logic        acc, ov;
        logic [31:0] w;
        int          lat, idx;
        bus_a.i_VALID = 1'b0; bus_a.i_FIXED_WORD = 32'h0; bus_a.i_READY = 1'b1;
        bus_b.i_VALID = 1'b0; bus_b.i_FIXED_WORD = 32'h0; bus_b.i_READY = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check_val("rst_valid", 64'(bus_a.o_VALID), 64'd0);
        check_val("rst_ready", 64'(bus_a.o_READY), 64'd1);
        check_val("rst_outputs", 64'(cur_a()), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed corners, first one lands on the first edge after release.
        for (int i = 0; i < 7; i++) drive_cycle(1'b1, dir_in[i], 1'b1, dir_exp[i], acc, ov);
        drain();

        // Latency with downstream always ready.
        w = rand_word();
        drive_cycle(1'b1, w, 1'b1, ref_model(w, 0), acc, ov);
        lat = 0;
        ov  = 1'b0;
        while (!ov && lat < 10) begin
            drive_cycle(1'b0, 32'h0, 1'b1, '0, acc, ov);
            lat++;
        end
        check_val("latency", 64'(lat), 64'd3);

        // Eight back-to-back inputs with a five-cycle downstream stall mid-stream.
        idx = 0;
        w = rand_word();
        for (int c = 0; c < 40 && idx < 8; c++) begin
            drive_cycle(1'b1, w, !(c >= 4 && c < 9), ref_model(w, 0), acc, ov);
            if (acc) begin
                idx++;
                w = rand_word();
            end
        end
        check_val("bp_accepted", 64'(idx), 64'd8);
        drain();

        // Random traffic with random valid and ready.
        w = rand_word();
        for (int c = 0; c < 400; c++) begin
            drive_cycle($urandom_range(0, 3) != 0, w, $urandom_range(0, 9) < 7,
                        ref_model(w, 0), acc, ov);
            if (acc) w = rand_word();
        end
        drain();

        // Reset with three results in flight; none may reappear.
        for (int i = 0; i < 3; i++) begin
            w = rand_word();
            drive_cycle(1'b1, w, 1'b1, ref_model(w, 0), acc, ov);
        end
        #1;
        check_val("pre_rst_valid", 64'(bus_a.o_VALID), 64'd1);
        rst = 1'b1;
        #1;
        check_val("midrst_valid", 64'(bus_a.o_VALID), 64'd0);
        check_val("midrst_outputs", 64'(cur_a()), 64'd0);
        check_val("midrst_ready", 64'(bus_a.o_READY), 64'd1);
        exp_q.delete();
        stall_seen = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        drive_cycle(1'b1, 32'h0000_0005, 1'b1, ref_model(32'h0000_0005, 0), acc, ov);
        check_val("post_rst_accept", 64'(acc), 64'd1);
        for (int i = 0; i < 8; i++) drive_cycle(1'b0, 32'h0, 1'b1, '0, acc, ov);
        check_val("post_rst_empty", 64'(exp_q.size()), 64'd0);

        // Sixteen fractional bits on the second instance.
        run_b("frac16_1p5", 32'h0001_8000, {1'b0, 1'b0, 32'h3FC0_0000});
        run_b("frac16_m1", 32'hFFFF_0000, {1'b0, 1'b0, 32'hBF80_0000});
        for (int i = 0; i < 4; i++) begin
            w = rand_word();
            run_b("frac16_rand", w, ref_model(w, 16));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
